// File: rtl/mread_pkg.sv
// Shared core definitions: access size codes, memory-read FSM encoding and lane helpers.
package mread_pkg;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mread_state_t;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mread_if.sv
// Word-read channel between the memory-read stage (master) and the MMU (slave).
interface mread_if;

  logic        DATA_RDEN;
  logic [31:0] DATA_RADDR;
  logic        DATA_RVALID;
  logic [31:0] DATA_RDATA;

  modport master (
    output DATA_RDEN,
    output DATA_RADDR,
    input  DATA_RVALID,
    input  DATA_RDATA
  );

  modport slave (
    input  DATA_RDEN,
    input  DATA_RADDR,
    output DATA_RVALID,
    output DATA_RDATA
  );

endinterface

// File: rtl/mread_extract.sv
// Load-result extraction from an aligned word: lane select by byte offset, then zero/sign extension.
module mread_extract
  import mread_pkg::*;
(
  input  logic [31:0] i_rword,
  input  logic [1:0]  i_off,
  input  logic [3:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic [15:0] w_lo;

  // Only the low half of the shifted word is ever needed; wider results come straight from i_rword.
  assign w_lo = 16'(i_rword >> {i_off, 3'b000});

  always_comb begin
    o_data = i_rword;
    case (i_size)
      STRB_B:  o_data = ext_byte(w_lo[7:0], i_signed);
      STRB_H:  o_data = ext_half(w_lo, i_signed);
      default: o_data = i_rword;
    endcase
  end

endmodule

// File: rtl/mread.sv
// Memory-read pipeline stage: latches one exec instruction per unstalled cycle, fetches the aligned
// word for every load/store, and hands mwrite either the load result or the old word plus store lanes.
module mread
  import mread_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        FLUSH,
  output logic        MEM_WAIT,
  mread_if.master     mmu,
  input  logic [4:0]  EXEC_REG_W_RD,
  input  logic [31:0] EXEC_REG_W_DATA,
  input  logic [11:0] EXEC_CSR_W_ADDR,
  input  logic [31:0] EXEC_CSR_W_DATA,
  input  logic        EXEC_MEM_R_VALID,
  input  logic [4:0]  EXEC_MEM_R_RD,
  input  logic        EXEC_MEM_R_SIGNED,
  input  logic        EXEC_MEM_W_VALID,
  input  logic [31:0] EXEC_MEM_ADDR,
  input  logic [3:0]  EXEC_MEM_STRB,
  input  logic [31:0] EXEC_MEM_W_DATA,
  output logic        MEMR_MEM_R_VALID,
  output logic [4:0]  MEMR_MEM_R_RD,
  output logic [31:0] MEMR_MEM_R_DATA,
  output logic [4:0]  MEMR_REG_W_RD,
  output logic [31:0] MEMR_REG_W_DATA,
  output logic [11:0] MEMR_CSR_W_ADDR,
  output logic [31:0] MEMR_CSR_W_DATA,
  output logic        MEMR_MEM_W_VALID,
  output logic [31:0] MEMR_MEM_W_ADDR,
  output logic [3:0]  MEMR_MEM_W_STRB,
  output logic [31:0] MEMR_MEM_W_DATA
);

  mread_state_t r_state;
  logic         r_r_valid;
  logic         r_r_signed;
  logic         r_w_valid;
  logic [4:0]   r_r_rd;
  logic [4:0]   r_reg_w_rd;
  logic [31:0]  r_reg_w_data;
  logic [11:0]  r_csr_w_addr;
  logic [31:0]  r_csr_w_data;
  logic [31:0]  r_addr;
  logic [3:0]   r_strb;
  logic [31:0]  r_w_data;
  logic [31:0]  r_rword;

  logic [1:0]   w_off;
  logic         w_done;
  logic [31:0]  w_ld_data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_r_valid    <= 1'b0;
      r_r_signed   <= 1'b0;
      r_w_valid    <= 1'b0;
      r_r_rd       <= '0;
      r_reg_w_rd   <= '0;
      r_reg_w_data <= '0;
      r_csr_w_addr <= '0;
      r_csr_w_data <= '0;
      r_addr       <= '0;
      r_strb       <= '0;
      r_w_data     <= '0;
      r_rword      <= '0;
    end else if (r_state == WAIT) begin
      // The latched instruction is frozen until the MMU answers.
      if (mmu.DATA_RVALID) begin
        r_rword <= mmu.DATA_RDATA;
        r_state <= DONE;
      end
    end else if (!STALL) begin
      r_r_valid    <= EXEC_MEM_R_VALID & ~FLUSH;
      r_w_valid    <= EXEC_MEM_W_VALID & ~FLUSH;
      r_r_rd       <= FLUSH ? 5'd0 : EXEC_MEM_R_RD;
      r_reg_w_rd   <= FLUSH ? 5'd0 : EXEC_REG_W_RD;
      r_csr_w_addr <= FLUSH ? 12'd0 : EXEC_CSR_W_ADDR;
      r_r_signed   <= EXEC_MEM_R_SIGNED;
      r_reg_w_data <= EXEC_REG_W_DATA;
      r_csr_w_data <= EXEC_CSR_W_DATA;
      r_addr       <= EXEC_MEM_ADDR;
      r_strb       <= EXEC_MEM_STRB;
      r_w_data     <= EXEC_MEM_W_DATA;
      r_state      <= (!FLUSH && (EXEC_MEM_R_VALID || EXEC_MEM_W_VALID)) ? WAIT : IDLE;
    end
  end

  assign w_off  = r_addr[1:0];
  assign w_done = (r_state == DONE);

  mread_extract u_extract (
    .i_rword  (r_rword),
    .i_off    (w_off),
    .i_size   (r_strb),
    .i_signed (r_r_signed),
    .o_data   (w_ld_data)
  );

  assign MEM_WAIT       = (r_state == WAIT);
  assign mmu.DATA_RDEN  = MEM_WAIT;
  assign mmu.DATA_RADDR = {r_addr[31:2], 2'b00};

  // A store owns the slot when both flags are set; mwrite merges into the old word.
  assign MEMR_MEM_R_VALID = r_r_valid & ~r_w_valid & w_done;
  assign MEMR_MEM_R_RD    = r_r_rd;
  assign MEMR_MEM_R_DATA  = r_w_valid ? r_rword : (r_r_valid ? w_ld_data : 32'd0);
  assign MEMR_REG_W_RD    = r_r_valid ? 5'd0 : r_reg_w_rd;
  assign MEMR_REG_W_DATA  = r_reg_w_data;
  assign MEMR_CSR_W_ADDR  = r_csr_w_addr;
  assign MEMR_CSR_W_DATA  = r_csr_w_data;
  assign MEMR_MEM_W_VALID = r_w_valid & w_done;
  assign MEMR_MEM_W_ADDR  = r_addr;
  assign MEMR_MEM_W_STRB  = r_strb << w_off;
  assign MEMR_MEM_W_DATA  = r_w_data << {w_off, 3'b000};

endmodule
